cmd_parser_p: RTL and testbench

//  Parametrised successor to the glitcher UART command decoder. Consumes bytes from uart_rx and

---
 rtl/cmd_pkg.sv | 14 +
 rtl/cmd_arg_shift.sv | 40 ++++
 rtl/cmd_parser_p.sv | 196 +++++++++++++++++++
 tb/tb_cmd_parser_p.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared opcodes and state/target encodings for the UART command parser.
package cmd_pkg;

  localparam logic [7:0] ESC    = 8'h00;
  localparam logic [7:0] OP_RST = 8'hFF;
  localparam logic [7:0] OP_PW  = 8'h10;
  localparam logic [7:0] OP_PC  = 8'h11;
  localparam logic [7:0] OP_DLY = 8'h12;
  localparam logic [7:0] OP_ARM = 8'h20;

  typedef enum logic [2:0] {IDLE, CMD, ARG, DATA, DRAIN} state_t;
  typedef enum logic [1:0] {TGT_PW, TGT_PC, TGT_DLY} tgt_t;

endpackage

// File: rtl/cmd_arg_shift.sv
// Little-endian argument assembler: collects ARG_BYTES bytes and presents the
// complete value combinationally while the final byte is on din.
module cmd_arg_shift #(
  parameter int ARG_BYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [7:0]               din,
  output logic                     last,
  output logic [8*ARG_BYTES-1:0]   value
);

  localparam int AW = 8 * ARG_BYTES;

  logic [7:0]    cnt_reg;
  logic [AW-1:0] bytes_q;

  assign last  = (cnt_reg == 8'(ARG_BYTES - 1));
  // Top byte slot is still zero here, so OR-ing din in yields the full value.
  assign value = bytes_q | (AW'(din) << (8 * (ARG_BYTES - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_reg <= '0;
    else if (clr)    cnt_reg <= '0;
    else if (en)     cnt_reg <= last ? 8'd0 : cnt_reg + 8'd1;
  end

  for (genvar gi = 0; gi < ARG_BYTES; gi++) begin : g_byte
    logic [7:0] b_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           b_reg <= '0;
      else if (clr)                         b_reg <= '0;
      else if (en && cnt_reg == 8'(gi))     b_reg <= din;
    end
    assign bytes_q[gi*8 +: 8] = b_reg;
  end

endmodule

// File: rtl/cmd_parser_p.sv
// Escaped UART command decoder: numeric arguments, pattern upload, arm and
// soft reset, with an inter-byte timeout that resynchronises the stream.
module cmd_parser_p
  import cmd_pkg::*;
#(
  parameter int ARG_BYTES   = 2,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int TIMEOUT_CYC = 120000,
  parameter int PW_DEFAULT  = 1,
  parameter int PC_DEFAULT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   pat_we,
  output logic [ADDR_W-1:0]      pat_addr,
  output logic [7:0]             pat_wdata,
  output logic [ADDR_W:0]        pat_len,
  output logic                   pat_done,
  output logic [8*ARG_BYTES-1:0] pulse_width,
  output logic [8*ARG_BYTES-1:0] pulse_count,
  output logic [8*ARG_BYTES-1:0] pulse_delay,
  output logic                   arm,
  output logic                   soft_rst,
  output logic                   err
);

  localparam int AW = 8 * ARG_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            state_reg, state_next;
  tgt_t              tgt_reg, tgt_next;
  logic [7:0]        rem_reg, rem_next;     // 8 bits: drain length can be up to 255
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [TW-1:0]     to_cnt_reg;
  logic              pat_we_reg, pat_we_next, pat_done_reg, pat_done_next;
  logic [ADDR_W-1:0] pat_addr_reg, pat_addr_next;
  logic [7:0]        pat_wdata_reg, pat_wdata_next;
  logic [ADDR_W:0]   pat_len_reg, pat_len_next;
  logic [AW-1:0]     pw_reg, pw_next, pc_reg, pc_next, pd_reg, pd_next;
  logic              arm_reg, arm_next, srst_reg, srst_next, err_reg, err_next;
  logic              timeout, arg_last;
  logic [AW-1:0]     arg_value;

  cmd_arg_shift #(.ARG_BYTES(ARG_BYTES)) u_arg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_reg != ARG),
    .en    (rx_valid && state_reg == ARG),
    .din   (rx_data),
    .last  (arg_last),
    .value (arg_value)
  );

  // A byte arriving on the expiry cycle suppresses the timeout.
  assign timeout = (state_reg != IDLE) && !rx_valid && (to_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             to_cnt_reg <= '0;
    else if (rx_valid || state_reg == IDLE) to_cnt_reg <= '0;
    else                                    to_cnt_reg <= to_cnt_reg + TW'(1);
  end

  always_comb begin
    state_next     = state_reg;
    tgt_next       = tgt_reg;
    rem_next       = rem_reg;
    idx_next       = idx_reg;
    pat_addr_next  = pat_addr_reg;
    pat_wdata_next = pat_wdata_reg;
    pat_len_next   = pat_len_reg;
    pw_next        = pw_reg;
    pc_next        = pc_reg;
    pd_next        = pd_reg;
    pat_we_next    = 1'b0;
    pat_done_next  = 1'b0;
    arm_next       = 1'b0;
    srst_next      = 1'b0;
    err_next       = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end else if (rx_valid) begin
      case (state_reg)
        IDLE: begin
          if (rx_data == ESC) begin
            state_next = CMD;
          end else if (int'(rx_data) <= DEPTH) begin
            state_next    = DATA;
            rem_next      = rx_data;
            idx_next      = '0;
            pat_addr_next = '0;
          end else begin
            state_next = DRAIN;
            rem_next   = rx_data;
            err_next   = 1'b1;
          end
        end
        CMD: begin
          state_next = IDLE;
          case (rx_data)
            OP_RST: begin
              srst_next = 1'b1;
              pw_next   = AW'(PW_DEFAULT);
              pc_next   = AW'(PC_DEFAULT);
              pd_next   = '0;
            end
            OP_PW:   begin tgt_next = TGT_PW;  state_next = ARG; end
            OP_PC:   begin tgt_next = TGT_PC;  state_next = ARG; end
            OP_DLY:  begin tgt_next = TGT_DLY; state_next = ARG; end
            OP_ARM:  arm_next = 1'b1;
            default: err_next = 1'b1;
          endcase
        end
        ARG: begin
          if (arg_last) begin
            state_next = IDLE;
            case (tgt_reg)
              TGT_PW:  pw_next = arg_value;
              TGT_PC:  pc_next = arg_value;
              default: pd_next = arg_value;
            endcase
          end
        end
        DATA: begin
          pat_we_next    = 1'b1;
          pat_wdata_next = rx_data;
          pat_addr_next  = idx_reg[ADDR_W-1:0];
          idx_next       = idx_reg + (ADDR_W+1)'(1);
          rem_next       = rem_reg - 8'd1;
          if (rem_reg == 8'd1) begin
            pat_len_next  = idx_reg + (ADDR_W+1)'(1);
            pat_done_next = 1'b1;
            state_next    = IDLE;
          end
        end
        DRAIN: begin
          rem_next = rem_reg - 8'd1;
          if (rem_reg == 8'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tgt_reg       <= TGT_PW;
      rem_reg       <= '0;
      idx_reg       <= '0;
      pat_we_reg    <= 1'b0;
      pat_addr_reg  <= '0;
      pat_wdata_reg <= '0;
      pat_len_reg   <= '0;
      pat_done_reg  <= 1'b0;
      pw_reg        <= AW'(PW_DEFAULT);
      pc_reg        <= AW'(PC_DEFAULT);
      pd_reg        <= '0;
      arm_reg       <= 1'b0;
      srst_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tgt_reg       <= tgt_next;
      rem_reg       <= rem_next;
      idx_reg       <= idx_next;
      pat_we_reg    <= pat_we_next;
      pat_addr_reg  <= pat_addr_next;
      pat_wdata_reg <= pat_wdata_next;
      pat_len_reg   <= pat_len_next;
      pat_done_reg  <= pat_done_next;
      pw_reg        <= pw_next;
      pc_reg        <= pc_next;
      pd_reg        <= pd_next;
      arm_reg       <= arm_next;
      srst_reg      <= srst_next;
      err_reg       <= err_next;
    end
  end

  assign pat_we      = pat_we_reg;
  assign pat_addr    = pat_addr_reg;
  assign pat_wdata   = pat_wdata_reg;
  assign pat_len     = pat_len_reg;
  assign pat_done    = pat_done_reg;
  assign pulse_width = pw_reg;
  assign pulse_count = pc_reg;
  assign pulse_delay = pd_reg;
  assign arm         = arm_reg;
  assign soft_rst    = srst_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_cmd_parser_p.sv
// Bench for cmd_parser_p: directed vector table, multi-cycle corner sequences and
// a randomized byte stream checked against a command-level reference model.
module tb_cmd_parser_p;

  localparam int T = 60;

  logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        pat_we, pat_done, arm, soft_rst, err;
  logic [4:0]  pat_addr;
  logic [7:0]  pat_wdata;
  logic [5:0]  pat_len;
  logic [15:0] pulse_width, pulse_count, pulse_delay;

  cmd_parser_p #(
    .ARG_BYTES(2), .DEPTH(32), .TIMEOUT_CYC(T), .PW_DEFAULT(1), .PC_DEFAULT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata), .pat_len(pat_len),
    .pat_done(pat_done), .pulse_width(pulse_width), .pulse_count(pulse_count),
    .pulse_delay(pulse_delay), .arm(arm), .soft_rst(soft_rst), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: command-level view of the byte stream.
  int          m_mode, m_rem, m_idx, m_idle, m_tgt;
  logic [7:0]  m_argq[$];
  logic [15:0] m_pw, m_pc, m_pd;
  logic [5:0]  m_len;
  logic [4:0]  m_addr;
  logic [7:0]  m_wd;
  logic        m_we, m_done, m_arm, m_srst, m_err;

  function automatic logic [71:0] pk(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                                     input logic done, input logic [5:0] len, input logic [15:0] pw,
                                     input logic [15:0] pc, input logic [15:0] pd,
                                     input logic a, input logic s, input logic e);
    return {we, we ? addr : 5'd0, we ? wd : 8'd0, done, len, pw, pc, pd, a, s, e};
  endfunction

  function automatic logic [71:0] dut_vec();
    return pk(pat_we, pat_addr, pat_wdata, pat_done, pat_len, pulse_width, pulse_count,
              pulse_delay, arm, soft_rst, err);
  endfunction

  function automatic logic [71:0] mdl_vec();
    return pk(m_we, m_addr, m_wd, m_done, m_len, m_pw, m_pc, m_pd, m_arm, m_srst, m_err);
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_rem = 0; m_idx = 0; m_idle = 0; m_tgt = 0;
    m_argq.delete();
    m_pw = 16'd1; m_pc = 16'd1; m_pd = 16'd0; m_len = 6'd0;
    m_addr = 5'd0; m_wd = 8'd0;
    m_we = 0; m_done = 0; m_arm = 0; m_srst = 0; m_err = 0;
  endfunction

  function automatic void m_step(input logic v, input logic [7:0] d);
    int val;
    m_we = 0; m_done = 0; m_arm = 0; m_srst = 0; m_err = 0;
    if (!v) begin
      if (m_mode != 0) begin
        m_idle++;
        if (m_idle == T) begin m_err = 1; m_mode = 0; m_argq.delete(); end
      end
    end else begin
      m_idle = 0;
      case (m_mode)
        0: if (d == 8'h00) m_mode = 1;
           else if (int'(d) <= 32) begin m_mode = 3; m_rem = int'(d); m_idx = 0; end
           else begin m_err = 1; m_mode = 4; m_rem = int'(d); end
        1: begin
          m_mode = 0;
          case (d)
            8'hFF: begin m_srst = 1; m_pw = 16'd1; m_pc = 16'd1; m_pd = 16'd0; end
            8'h10, 8'h11, 8'h12: begin m_tgt = int'(d); m_argq.delete(); m_mode = 2; end
            8'h20: m_arm = 1;
            default: m_err = 1;
          endcase
        end
        2: begin
          m_argq.push_back(d);
          if (m_argq.size() == 2) begin
            val = int'(m_argq[0]) + 256 * int'(m_argq[1]);
            if (m_tgt == 'h10) m_pw = 16'(val);
            else if (m_tgt == 'h11) m_pc = 16'(val);
            else m_pd = 16'(val);
            m_mode = 0;
          end
        end
        3: begin
          m_we = 1; m_addr = 5'(m_idx); m_wd = d; m_idx++;
          if (m_idx == m_rem) begin m_len = 6'(m_rem); m_done = 1; m_mode = 0; end
        end
        default: begin m_rem--; if (m_rem == 0) m_mode = 0; end
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25) $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v; rx_data = d;
    m_step(v, d);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic cyc_m(input logic v, input logic [7:0] d, input string name);
    cyc(v, d);
    chk(name, dut_vec(), mdl_vec());
  endtask

  typedef struct { logic [7:0] d; logic [71:0] exp; } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic we, input logic [4:0] a,
                              input logic [7:0] wd, input logic dn, input logic [5:0] len,
                              input logic [15:0] pw, input logic [15:0] pc, input logic [15:0] pd,
                              input logic ar, input logic sr, input logic er);
    vec_t r;
    r.d = d; r.exp = pk(we, a, wd, dn, len, pw, pc, pd, ar, sr, er);
    return r;
  endfunction

  initial begin
    int errs, wes, err_last;
    logic [7:0] b;
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 8'h00, 0, 0, 16'h0001, 16'h0001, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h10, 0, 0, 8'h00, 0, 0, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'hAA, 0, 0, 8'h00, 0, 0, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h01, 0, 0, 8'h00, 0, 0, 16'h01AA, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 16'h01AA, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h11, 0, 0, 8'h00, 0, 0, 16'h01AA, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h55, 0, 0, 8'h00, 0, 0, 16'h01AA, 16'h0001, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h05, 0, 0, 8'h00, 0, 0, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'hAA, 1, 0, 8'hAA, 0, 0, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h55, 1, 1, 8'h55, 0, 0, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h00, 1, 2, 8'h00, 0, 0, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'hFF, 1, 3, 8'hFF, 0, 0, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 1, 4, 8'hF0, 1, 5, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h12, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h34, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(8'h12, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(8'h20, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h1234, 1, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(8'h77, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h1234, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0, 5, 16'h01AA, 16'h0055, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 8'h00, 0, 5, 16'h0001, 16'h0001, 16'h0000, 0, 1, 0));

    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset", dut_vec(), pk(0, 0, 0, 0, 0, 16'd1, 16'd1, 16'd0, 0, 0, 0));
    chk("reset_addr", 72'(pat_addr), 72'd0);

    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].d);
      $display("vec %0d rx=%02h out=%h", i, tbl[i].d, dut_vec());
      chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Oversize length: one err, bytes swallowed, framing intact afterwards.
    errs = 0; wes = 0;
    cyc_m(1'b1, 8'h40, "drain_hdr");
    errs += int'(err);
    for (int i = 0; i < 64; i++) begin
      cyc_m(1'b1, 8'($urandom), "drain_body");
      errs += int'(err); wes += int'(pat_we);
    end
    chk("drain_err", 72'(errs), 72'd1);
    chk("drain_we", 72'(wes), 72'd0);
    cyc_m(1'b1, 8'h00, "drain_esc");
    cyc_m(1'b1, 8'h20, "drain_arm_m");
    chk("drain_arm", 72'(arm), 72'd1);
    $display("drain sequence errs=%0d writes=%0d", errs, wes);

    // Partial argument abandoned by timeout.
    cyc_m(1'b1, 8'h00, "to_esc");
    cyc_m(1'b1, 8'h12, "to_op");
    cyc_m(1'b1, 8'h34, "to_arg");
    errs = 0; err_last = 0;
    for (int i = 0; i < T; i++) begin
      cyc_m(1'b0, 8'h00, "to_idle");
      errs += int'(err); err_last = int'(err);
    end
    chk("to_err_count", 72'(errs), 72'd1);
    chk("to_err_last", 72'(err_last), 72'd1);
    chk("to_delay_kept", 72'(pulse_delay), 72'd0);
    cyc_m(1'b1, 8'h00, "to_esc2");
    cyc_m(1'b1, 8'h20, "to_arm_m");
    chk("to_arm", 72'(arm), 72'd1);
    $display("timeout sequence errs=%0d", errs);

    // Byte landing exactly on the expiry cycle is processed normally.
    cyc_m(1'b1, 8'h00, "edge_esc");
    cyc_m(1'b1, 8'h12, "edge_op");
    errs = 0;
    for (int i = 0; i < T - 1; i++) begin
      cyc_m(1'b0, 8'h00, "edge_idle");
      errs += int'(err);
    end
    cyc_m(1'b1, 8'h56, "edge_lo");
    errs += int'(err);
    cyc_m(1'b1, 8'h78, "edge_hi");
    errs += int'(err);
    chk("edge_no_err", 72'(errs), 72'd0);
    chk("edge_delay", 72'(pulse_delay), 72'h7856);
    $display("timeout-edge sequence delay=%h", pulse_delay);

    // Asynchronous reset in the middle of a pattern upload.
    cyc_m(1'b1, 8'h05, "rst_len");
    cyc_m(1'b1, 8'h11, "rst_d0");
    cyc_m(1'b1, 8'h22, "rst_d1");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", dut_vec(), pk(0, 0, 0, 0, 0, 16'd1, 16'd1, 16'd0, 0, 0, 0));
    chk("rst_async_addr", 72'(pat_addr), 72'd0);
    m_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cyc_m(1'b1, 8'h03, "post_len");
    cyc_m(1'b1, 8'hA1, "post_d0");
    chk("post_addr0", {63'd0, pat_we, 3'd0, pat_addr}, {63'd0, 1'b1, 8'd0});
    cyc_m(1'b1, 8'hB2, "post_d1");
    cyc_m(1'b1, 8'hC3, "post_d2");
    chk("post_len3", {65'd0, pat_done, pat_len}, {65'd0, 1'b1, 6'd3});
    $display("reset-mid-data sequence len=%0d", pat_len);

    // Randomized stream against the model.
    for (int i = 0; i < 3000; i++) begin
      int r, s;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        for (int k = 0; k < T + 3; k++) cyc_m(1'b0, 8'h00, "rand_gap");
      end else if (r < 40) begin
        cyc_m(1'b0, 8'h00, "rand_idle");
      end else begin
        s = $urandom_range(0, 9);
        case (s)
          0, 1, 2: b = 8'h00;
          3:       b = 8'hFF;
          4:       b = 8'(8'h10 + $urandom_range(0, 2));
          5:       b = 8'h20;
          6:       b = 8'($urandom_range(1, 8));
          7:       b = 8'($urandom_range(30, 36));
          default: b = 8'($urandom);
        endcase
        cyc_m(1'b1, b, "rand_byte");
      end
    end
    $display("random stream done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
